rot_intr_ctrl: RTL
==================

Name: rot_intr_ctrl

Overview:
- Completion tracker and interrupt generator for the rotation engine, driving the top-level O_INTR_DONE output.
- Consumes the START/RESET controls and mask/clear bits from the register file, plus per-pixel write-completion pulses from the DMA.
- Counts written output pixels against IMG_NEW_H*IMG_NEW_W, holds sticky start/done status, and produces one masked, registered interrupt line.

Parameters:
- CNT_W, 32, width of pixel counter and target (covers 16b x 16b product)

Ports:
- I_INTR_HCLK  input  1  AHB-domain clock, rising edge
- I_INTR_HRESET_N  input  1  asynchronous active-low hard reset
- I_INTR_RESET  input  1  soft reset from register file, synchronous, active-high
- I_INTR_START  input  1  start level from register file; rising edge launches a job
- I_INTR_NEW_H  input  16  rotated image height from core_set
- I_INTR_NEW_W  input  16  rotated image width from core_set
- I_INTR_PIX_DONE  input  1  one-cycle pulse per output pixel write completed by DMA
- I_INTR_MASK  input  1  global interrupt mask (1 = masked)
- I_INTR_BEF_MASK  input  1  mask for start-accepted ("before") event
- I_INTR_AFT_MASK  input  1  mask for job-complete ("after") event
- I_INTR_CLEAR  input  1  one-cycle pulse clearing both sticky status bits
- O_INTR_DONE  output  1  registered masked interrupt
- O_INTR_BUSY  output  1  high while state is RUN
- O_INTR_RAW_BEF  output  1  sticky unmasked start event
- O_INTR_RAW_AFT  output  1  sticky unmasked done event
- O_INTR_PIX_CNT  output  CNT_W  output pixels counted in current/last job

Behaviour:
- Hard reset values: all outputs 0; state IDLE; start edge register 0; target 0.
- Soft reset (I_INTR_RESET=1): same values as hard reset, applied on the next clock edge. Overrides every other input. Abandons a job in RUN with no interrupt.
- Start detect: start_q registers I_INTR_START each cycle. start_rise = I_INTR_START & ~start_q.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start_rise:
  - target <= NEW_H*NEW_W, unsigned, CNT_W wide.
  - PIX_CNT <= 0.
  - RAW_BEF <= 1.
- IDLE with a zero target (NEW_H=0 or NEW_W=0):
  - Go directly to DONE.
  - Set RAW_BEF and RAW_AFT on the same edge.
- RUN:
  - Each PIX_DONE pulse increments PIX_CNT.
  - When PIX_DONE arrives with PIX_CNT == target-1: PIX_CNT <= target, RAW_AFT <= 1, go to DONE. RAW_AFT therefore rises 1 cycle after the final pulse.
  - start_rise in RUN is ignored.
- DONE:
  - PIX_DONE pulses are ignored; the counter saturates at target.
  - start_rise behaves as in IDLE. RAW_AFT is left unchanged until cleared.
  - With no start_rise, DONE returns to IDLE one cycle after entry.
- PIX_DONE while IDLE is ignored.
- NEW_H/NEW_W are sampled only at start. Changes mid-job have no effect.
- CLEAR pulse clears RAW_BEF and RAW_AFT on the next edge.
  - If a set event occurs in the same cycle as CLEAR, the set wins for that bit.
- O_INTR_DONE is a register, updated every cycle to ~MASK & ((RAW_BEF & ~BEF_MASK) | (RAW_AFT & ~AFT_MASK)), computed from the current-cycle RAW values.
  - Net effect: O_INTR_DONE lags RAW by 1 cycle and lags a mask change by 1 cycle.
- Unmasking a pending sticky bit asserts O_INTR_DONE 1 cycle later. Masking only hides the bit; it never clears RAW.
- O_INTR_BUSY = (state == RUN), registered along with the state.
- Async hard-reset assertion mid-job forces all outputs to 0 immediately, without waiting for a clock edge.

Test Plan:
- Basic job: NEW_H=2, NEW_W=3, masks 0, start rise, six PIX_DONE pulses -> RAW_BEF=1 one cycle after start; PIX_CNT steps 1..6; RAW_AFT=1 the cycle after pulse 6; O_INTR_DONE=1 one cycle after RAW_BEF and stays 1; BUSY low after completion.
- Masking: BEF_MASK=1, AFT_MASK=0, run a 1x4 job -> O_INTR_DONE=0 until RAW_AFT sets, then 1. Then set MASK=1 -> O_INTR_DONE=0 next cycle while RAW_AFT stays 1.
- Clear collision: job with target 1. Pulse CLEAR in the same cycle as the single PIX_DONE -> RAW_BEF=0, RAW_AFT=1. A second CLEAR -> both 0, O_INTR_DONE=0 one cycle later.
- Zero size: NEW_W=0, start rise -> RAW_BEF=RAW_AFT=1 on the same edge; PIX_CNT=0; BUSY never asserts.
- Extra pulses and restart: target 2, send 4 PIX_DONE -> PIX_CNT holds 2. Restart with START low->high -> PIX_CNT resets to 0, BUSY=1. A start_rise during RUN is ignored (target unchanged).
- Resets: soft RESET after 3 of 8 pixels -> all outputs 0, state IDLE, no interrupt. Async HRESET_N low mid-cycle -> outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/rot_intr_ctrl.sv
// Completion tracker and interrupt generator for the rotation engine.
// Counts DMA pixel completions against NEW_H*NEW_W and raises one masked, registered interrupt.
module rot_intr_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             I_INTR_HCLK,
    input  logic             I_INTR_HRESET_N,
    input  logic             I_INTR_RESET,
    input  logic             I_INTR_START,
    input  logic [15:0]      I_INTR_NEW_H,
    input  logic [15:0]      I_INTR_NEW_W,
    input  logic             I_INTR_PIX_DONE,
    input  logic             I_INTR_MASK,
    input  logic             I_INTR_BEF_MASK,
    input  logic             I_INTR_AFT_MASK,
    input  logic             I_INTR_CLEAR,
    output logic             O_INTR_DONE,
    output logic             O_INTR_BUSY,
    output logic             O_INTR_RAW_BEF,
    output logic             O_INTR_RAW_AFT,
    output logic [CNT_W-1:0] O_INTR_PIX_CNT
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             start_q;
    logic             start_rise;
    logic [CNT_W-1:0] new_size;
    logic [CNT_W-1:0] target, target_nxt;
    logic [CNT_W-1:0] pix_cnt, pix_cnt_nxt;
    logic             raw_bef, raw_bef_nxt;
    logic             raw_aft, raw_aft_nxt;
    logic             bef_set, aft_set;
    logic             intr_q, intr_nxt;

    assign start_rise = I_INTR_START & ~start_q;
    assign new_size   = CNT_W'(I_INTR_NEW_H) * CNT_W'(I_INTR_NEW_W);

    always_ff @(posedge I_INTR_HCLK or negedge I_INTR_HRESET_N) begin
        if (!I_INTR_HRESET_N) begin
            state <= IDLE;
        end else if (I_INTR_RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        pix_cnt_nxt = pix_cnt;
        bef_set     = 1'b0;
        aft_set     = 1'b0;
        case (state)
            IDLE, DONE: begin
                // A zero-sized job completes on the same edge it is accepted.
                if (start_rise) begin
                    target_nxt  = new_size;
                    pix_cnt_nxt = '0;
                    bef_set     = 1'b1;
                    if (new_size == '0) begin
                        aft_set   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (I_INTR_PIX_DONE) begin
                    if (pix_cnt == target - CNT_W'(1)) begin
                        pix_cnt_nxt = target;
                        aft_set     = 1'b1;
                        state_nxt   = DONE;
                    end else begin
                        pix_cnt_nxt = pix_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A set event in the same cycle as CLEAR keeps the bit set.
        raw_bef_nxt = bef_set | (raw_bef & ~I_INTR_CLEAR);
        raw_aft_nxt = aft_set | (raw_aft & ~I_INTR_CLEAR);
        intr_nxt    = ~I_INTR_MASK & ((raw_bef & ~I_INTR_BEF_MASK) | (raw_aft & ~I_INTR_AFT_MASK));
    end

    always_ff @(posedge I_INTR_HCLK or negedge I_INTR_HRESET_N) begin
        if (!I_INTR_HRESET_N) begin
            start_q <= 1'b0;
            target  <= '0;
            pix_cnt <= '0;
            raw_bef <= 1'b0;
            raw_aft <= 1'b0;
            intr_q  <= 1'b0;
        end else if (I_INTR_RESET) begin
            start_q <= 1'b0;
            target  <= '0;
            pix_cnt <= '0;
            raw_bef <= 1'b0;
            raw_aft <= 1'b0;
            intr_q  <= 1'b0;
        end else begin
            start_q <= I_INTR_START;
            target  <= target_nxt;
            pix_cnt <= pix_cnt_nxt;
            raw_bef <= raw_bef_nxt;
            raw_aft <= raw_aft_nxt;
            intr_q  <= intr_nxt;
        end
    end

    assign O_INTR_DONE    = intr_q;
    assign O_INTR_BUSY    = (state == RUN);
    assign O_INTR_RAW_BEF = raw_bef;
    assign O_INTR_RAW_AFT = raw_aft;
    assign O_INTR_PIX_CNT = pix_cnt;

endmodule
